// File: rtl/fast_square_sweep_ctrl_pkg.sv
// Shared state encoding and width helper for the fast-square sweep sequencer.
// No logic of its own; no latency or backpressure.
package fast_square_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SWEEP_RST = 3'd0,
    S_GUARD     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_RECORD    = 3'd3,
    S_NEXT      = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/fast_square_sweep_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous level; 2-cycle latency, no backpressure.
module fast_square_sweep_ctrl_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer: synth reset/step pulses, PLL-lock wait, fixed record window per step.
// Outputs registered (1-cycle after decision); free-running, waits only on lock, no backpressure.
module fast_square_sweep_ctrl
  import fast_square_sweep_ctrl_pkg::*;
#(
  parameter int NUM_FREQ_STEPS = 34,
  parameter int RECORD_TICKS   = 35000,
  parameter int PULSE_TICKS    = 64,
  parameter int GUARD_TICKS    = 256,
  parameter int LOCK_TICKS     = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       freq_step_reset_out,
  output logic       freq_step_out,
  output logic       rx_reset,
  output logic       rx_next,
  output logic       rx_record,
  output logic [3:0] debug
);

  localparam int MAX_A     = (RECORD_TICKS > PULSE_TICKS) ? RECORD_TICKS : PULSE_TICKS;
  localparam int MAX_B     = (GUARD_TICKS > LOCK_TICKS) ? GUARD_TICKS : LOCK_TICKS;
  localparam int MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW        = clog2(MAX_TICKS) + 1;
  localparam int SW        = clog2(NUM_FREQ_STEPS) + 1;

  localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0] GUARD_LAST  = TW'(GUARD_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TICKS - 1);
  localparam logic [TW-1:0] RECORD_LAST = TW'(RECORD_TICKS - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(NUM_FREQ_STEPS - 1);

  state_t          state;
  logic [TW-1:0]   ticks;
  logic [SW-1:0]   step_idx;
  logic            lock_sync;

  fast_square_sweep_ctrl_sync2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .din   (pll_locked),
    .dout  (lock_sync)
  );

  assign debug = {lock_sync, state};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= S_SWEEP_RST;
      ticks               <= '0;
      step_idx            <= '0;
      freq_step_reset_out <= 1'b0;
      freq_step_out       <= 1'b0;
      rx_reset            <= 1'b1;
      rx_next             <= 1'b0;
      rx_record           <= 1'b0;
    end else begin
      case (state)
        S_SWEEP_RST: begin
          step_idx <= '0;
          rx_reset <= 1'b1;
          // Output resets low, so the first cycle after release only raises the pulse.
          if (!freq_step_reset_out) begin
            freq_step_reset_out <= 1'b1;
          end else if (ticks == PULSE_LAST) begin
            state               <= S_GUARD;
            ticks               <= '0;
            freq_step_reset_out <= 1'b0;
            rx_reset            <= 1'b0;
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
        S_GUARD: begin
          if (ticks == GUARD_LAST) begin
            state <= S_WAIT_LOCK;
            ticks <= '0;
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (!lock_sync) begin
            ticks <= '0;
          end else if (ticks == LOCK_LAST) begin
            state     <= S_RECORD;
            ticks     <= '0;
            rx_record <= 1'b1;
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
        S_RECORD: begin
          if (ticks == RECORD_LAST) begin
            state     <= S_NEXT;
            ticks     <= '0;
            rx_record <= 1'b0;
            rx_next   <= 1'b1;
            if (step_idx != STEP_LAST) begin
              step_idx      <= step_idx + SW'(1);
              freq_step_out <= 1'b1;
            end
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
        S_NEXT: begin
          rx_next <= 1'b0;
          // A low step pulse on entry marks the last step of the sweep.
          if (!freq_step_out) begin
            state               <= S_SWEEP_RST;
            ticks               <= '0;
            step_idx            <= '0;
            freq_step_reset_out <= 1'b1;
            rx_reset            <= 1'b1;
          end else if (ticks == PULSE_LAST) begin
            state         <= S_GUARD;
            ticks         <= '0;
            freq_step_out <= 1'b0;
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
        default: begin
          state               <= S_SWEEP_RST;
          ticks               <= '0;
          step_idx            <= '0;
          freq_step_reset_out <= 1'b1;
          freq_step_out       <= 1'b0;
          rx_reset            <= 1'b1;
          rx_next             <= 1'b0;
          rx_record           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor measures and compares them.
module tb_fast_square_sweep_ctrl;

  localparam int NF = 3;
  localparam int RT = 10;
  localparam int PT = 4;
  localparam int GT = 5;
  localparam int LT = 8;

  localparam int K_RST       = 0;
  localparam int K_STEP      = 1;
  localparam int K_REC       = 2;
  localparam int K_NEXT_STEP = 3;
  localparam int K_NEXT_LAST = 4;
  localparam int K_GUARD     = 5;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       freq_step_reset_out;
  logic       freq_step_out;
  logic       rx_reset;
  logic       rx_next;
  logic       rx_record;
  logic [3:0] debug;

  typedef struct {
    int kind;
    int len;
    int aux;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  fast_square_sweep_ctrl #(
    .NUM_FREQ_STEPS (NF),
    .RECORD_TICKS   (RT),
    .PULSE_TICKS    (PT),
    .GUARD_TICKS    (GT),
    .LOCK_TICKS     (LT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .pll_locked          (pll_locked),
    .freq_step_reset_out (freq_step_reset_out),
    .freq_step_out       (freq_step_out),
    .rx_reset            (rx_reset),
    .rx_next             (rx_next),
    .rx_record           (rx_record),
    .debug               (debug)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int len, input int aux);
    exp_q.push_back('{kind, len, aux});
  endtask

  // One frequency step as seen on the outputs, from record window to the next wait.
  task automatic push_step(input bit last);
    push(K_REC, RT, LT);
    if (last) begin
      push(K_NEXT_LAST, 1, 0);
      push(K_RST, PT, 0);
      push(K_GUARD, GT, 0);
    end else begin
      push(K_NEXT_STEP, 1, 0);
      push(K_STEP, PT, 0);
      push(K_GUARD, GT, 0);
    end
  endtask

  task automatic emit(input int kind, input int len, input int aux);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d len %0d, none expected", kind, len);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk($sformatf("event%0d_len", e.kind), len, e.len);
    chk($sformatf("event%0d_lock_run", e.kind), aux, e.aux);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    chk("events_drained", exp_q.size(), 0);
  endtask

  task automatic wait_rec_rise(input int budget);
    int n;
    n = 0;
    @(posedge clock); #1;
    while (!rx_record && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("record_rise_seen", int'(rx_record), 1);
  endtask

  // Monitor: measures pulse widths, GUARD dwell and lock run before each record window.
  initial begin : monitor
    bit p_fsr, p_fs, p_rec, p_nx, nx_co;
    int p_st, st, l_fsr, l_fs, l_rec, l_nx, l_g, r_aux, lock_run;
    p_fsr = 0; p_fs = 0; p_rec = 0; p_nx = 0; nx_co = 0;
    p_st = 0; l_fsr = 0; l_fs = 0; l_rec = 0; l_nx = 0; l_g = 0; r_aux = 0; lock_run = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        p_fsr = 0; p_fs = 0; p_rec = 0; p_nx = 0; nx_co = 0;
        p_st = 0; l_fsr = 0; l_fs = 0; l_rec = 0; l_nx = 0; l_g = 0; lock_run = 0;
      end else begin
        st = int'(debug[2:0]);
        chk("excl_record_next", int'(rx_record & rx_next), 0);
        chk("excl_step_reset", int'(freq_step_out & freq_step_reset_out), 0);
        chk("excl_record_step", int'(rx_record & freq_step_out), 0);
        if (freq_step_reset_out) l_fsr++;
        else if (p_fsr) begin emit(K_RST, l_fsr, 0); l_fsr = 0; end
        if (rx_record) begin
          if (!p_rec) r_aux = lock_run;
          l_rec++;
        end else if (p_rec) begin
          emit(K_REC, l_rec, r_aux);
          l_rec = 0;
        end
        if (rx_next) begin
          if (!p_nx) nx_co = freq_step_out && !p_fs;
          l_nx++;
        end else if (p_nx) begin
          emit(nx_co ? K_NEXT_STEP : K_NEXT_LAST, l_nx, 0);
          l_nx = 0;
        end
        if (freq_step_out) l_fs++;
        else if (p_fs) begin emit(K_STEP, l_fs, 0); l_fs = 0; end
        if (st == 1) l_g++;
        else if (p_st == 1) begin emit(K_GUARD, l_g, 0); l_g = 0; end
        lock_run = (st == 2 && debug[3]) ? lock_run + 1 : 0;
        p_fsr = freq_step_reset_out; p_fs = freq_step_out;
        p_rec = rx_record; p_nx = rx_next; p_st = st;
      end
    end
  end

  initial begin
    reset = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("rst_rx_reset", int'(rx_reset), 1);
    chk("rst_sweep_reset", int'(freq_step_reset_out), 0);
    chk("rst_step", int'(freq_step_out), 0);
    chk("rst_next", int'(rx_next), 0);
    chk("rst_record", int'(rx_record), 0);
    chk("rst_debug", int'(debug), 0);

    // Release without lock: reset pulse, guard, then park in WAIT_LOCK.
    push(K_RST, PT, 0);
    push(K_GUARD, GT, 0);
    @(negedge clock); #1 reset = 1'b1;
    repeat (30) @(posedge clock); #1;
    chk("idle_debug_wait_lock", int'(debug), 2);
    chk("idle_no_record", int'(rx_record), 0);
    chk("idle_rx_reset_low", int'(rx_reset), 0);

    // Lock glitch restarts the count, then lock held for the whole sweep.
    push_step(1'b0);
    push_step(1'b0);
    push_step(1'b1);
    @(negedge clock) pll_locked = 1'b1;
    repeat (5) @(negedge clock);
    pll_locked = 1'b0;
    @(negedge clock) pll_locked = 1'b1;
    wait_drain(400);

    // Lock lost mid-record: window length unchanged.
    push_step(1'b0);
    wait_rec_rise(100);
    repeat (3) @(negedge clock);
    pll_locked = 1'b0;
    repeat (4) @(negedge clock);
    pll_locked = 1'b1;
    wait_drain(200);

    // Reset mid-record: outputs drop at once, sweep restarts from step 0.
    wait_rec_rise(100);
    #1 reset = 1'b0;
    #1;
    chk("async_record_drop", int'(rx_record), 0);
    chk("async_rx_reset", int'(rx_reset), 1);
    chk("async_next", int'(rx_next), 0);
    chk("async_step", int'(freq_step_out), 0);
    chk("async_sweep_reset", int'(freq_step_reset_out), 0);
    chk("async_debug", int'(debug), 0);
    repeat (3) @(negedge clock);
    push(K_RST, PT, 0);
    push(K_GUARD, GT, 0);
    push_step(1'b0);
    push_step(1'b0);
    push_step(1'b1);
    #1 reset = 1'b1;
    wait_drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
